// File: rtl/saph_raster_scan_ctrl.sv
// saph_raster_scan_ctrl: walks an inclusive bounding box in raster order.
// It drives row (Y-step) and pixel (X-step) attribute incrementers and emits
// one fragment per pixel through a valid/ready handshake.
//
// Optional build macro: SAPH_SCAN_WATCHDOG_EN adds an 'err' output and an
// 8-bit timeout on the incrementer ready waits.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start; box sampled with start
// S_LATCH_PX | pixel incrementer loads from the row incrementer
// S_EMIT     | fragment presented, waiting for frag_ready
// S_PX_WAIT  | pixel incrementer stepping X, waiting for px_ready
// S_ROW_WAIT | row incrementer stepping Y, waiting for row_ready
module saph_raster_scan_ctrl #(
  parameter int numbers = 2,
  parameter int cw      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [cw-1:0]      x0,
  input  logic [cw-1:0]      y0,
  input  logic [cw-1:0]      x1,
  input  logic [cw-1:0]      y1,
  output logic               busy,
  output logic               done,
  output logic               row_latch,
  output logic [numbers-1:0] row_count,
  input  logic               row_ready,
  output logic               px_latch,
  output logic [numbers-1:0] px_count,
  input  logic               px_ready,
  output logic               frag_valid,
  input  logic               frag_ready,
  output logic [cw-1:0]      frag_x,
  output logic [cw-1:0]      frag_y,
  output logic               frag_last
`ifdef SAPH_SCAN_WATCHDOG_EN
  ,
  output logic               err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH_PX,
    S_EMIT,
    S_PX_WAIT,
    S_ROW_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [cw-1:0] x0_q, x0_d;
  logic [cw-1:0] x1_q, x1_d;
  logic [cw-1:0] y1_q, y1_d;
  logic [cw-1:0] x_q, x_d;
  logic [cw-1:0] y_q, y_d;
  logic          done_q, done_d;

`ifdef SAPH_SCAN_WATCHDOG_EN
  // Timeout fires on the 255th consecutive wait cycle without ready.
  localparam logic [7:0] WD_LAST = 8'd254;
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  // State, box and coordinate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
`ifdef SAPH_SCAN_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= done_d;
`ifdef SAPH_SCAN_WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state, coordinate stepping and strobe decode.
  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    x_d        = x_q;
    y_d        = y_q;
    done_d     = 1'b0;
    row_latch  = 1'b0;
    row_count  = '0;
    px_latch   = 1'b0;
    px_count   = '0;
    frag_valid = 1'b0;
    frag_last  = 1'b0;
`ifdef SAPH_SCAN_WATCHDOG_EN
    wd_d       = '0;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is held off so that
        // row_latch and done never overlap.
        if (start && !done_q) begin
          if ((x1 >= x0) && (y1 >= y0)) begin
            row_latch = 1'b1;
            x0_d      = x0;
            x1_d      = x1;
            y1_d      = y1;
            x_d       = x0;
            y_d       = y0;
            state_d   = S_LATCH_PX;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LATCH_PX: begin
        px_latch = 1'b1;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        frag_valid = 1'b1;
        frag_last  = (x_q == x1_q) && (y_q == y1_q);
        if (frag_ready) begin
          // Compare before stepping so an all-ones bound never wraps.
          if (x_q < x1_q) begin
            px_count = '1;
            x_d      = x_q + 1'b1;
            state_d  = S_PX_WAIT;
          end else if (y_q < y1_q) begin
            row_count = '1;
            x_d       = x0_q;
            y_d       = y_q + 1'b1;
            state_d   = S_ROW_WAIT;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_PX_WAIT: begin
        if (px_ready) begin
          state_d = S_EMIT;
        end
`ifdef SAPH_SCAN_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      S_ROW_WAIT: begin
        if (row_ready) begin
          state_d = S_LATCH_PX;
        end
`ifdef SAPH_SCAN_WATCHDOG_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign frag_x = x_q;
  assign frag_y = y_q;
`ifdef SAPH_SCAN_WATCHDOG_EN
  assign err    = err_q;
`endif

endmodule

// File: doc/saph_raster_scan_ctrl.md
SAPH_RASTER_SCAN_CTRL -- requirements
Module: saph_raster_scan_ctrl

Interface
REQ-001 SHALL have parameter numbers, default 2: attribute lanes per incrementer; sets width of row_count/px_count.
REQ-002 SHALL have parameter cw, default 16: unsigned coordinate width.
REQ-003 clk  in  1  core clock; the only clock.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  begin scan of box; sampled only in IDLE.
REQ-006 x0,y0,x1,y1  in  cw each  inclusive bounding box; sampled with start.
REQ-007 busy  out  1  high in any state except IDLE.
REQ-008 done  out  1  one-cycle pulse when scan ends.
REQ-009 row_latch  out  1  latch strobe to row (Y-step) incrementer.
REQ-010 row_count  out  numbers  increment enable to row incrementer.
REQ-011 row_ready  in  1  row incrementer result ready.
REQ-012 px_latch  out  1  latch strobe to pixel (X-step) incrementer; its init is the row incrementer's current state.
REQ-013 px_count  out  numbers  increment enable to pixel incrementer.
REQ-014 px_ready  in  1  pixel incrementer result ready.
REQ-015 frag_valid / frag_ready  out / in  1 / 1  fragment handshake; attributes are the pixel incrementer's current state while frag_valid is high.
REQ-016 frag_x, frag_y  out  cw each  fragment coordinate.
REQ-017 frag_last  out  1  high with the final fragment of the box.

Function
REQ-018 SHALL implement states IDLE, LATCH_PX, EMIT, PX_WAIT, ROW_WAIT.
REQ-019 IDLE + start, x1>=x0 and y1>=y0: SHALL pulse row_latch, register box, set x=x0, y=y0, go LATCH_PX.
REQ-020 IDLE + start with x1<x0 or y1<y0: SHALL emit no fragment and pulse done the next cycle, remaining in IDLE.
REQ-021 LATCH_PX: SHALL pulse px_latch for exactly one cycle, then go EMIT.
REQ-022 EMIT: frag_valid high; frag_x/frag_y/frag_last SHALL hold stable until frag_ready; no count or latch output asserted.
REQ-023 EMIT handshake, x<x1: SHALL pulse px_count all-ones one cycle, x<=x+1, go PX_WAIT.
REQ-024 EMIT handshake, x==x1, y<y1: SHALL pulse row_count all-ones one cycle, x<=x0, y<=y+1, go ROW_WAIT.
REQ-025 EMIT handshake, x==x1, y==y1: SHALL pulse done and go IDLE.
REQ-026 PX_WAIT SHALL go EMIT on the cycle after px_ready is seen high; ROW_WAIT SHALL go LATCH_PX likewise on row_ready.
REQ-027 frag_last SHALL equal (x==x1 && y==y1) during EMIT, 0 otherwise.
REQ-028 start while busy SHALL be ignored.
REQ-029 Coordinate arithmetic is cw-bit unsigned; x1 or y1 equal to 2^cw-1 SHALL terminate without wrap-around.
REQ-030 All strobes (row_latch, px_latch, row_count, px_count, done) SHALL be single-cycle and mutually exclusive.

Reset
REQ-031 On rst, SHALL enter IDLE in the next cycle, including mid-scan, with no done pulse.
REQ-032 Reset values: busy, done, row_latch, row_count, px_latch, px_count, frag_valid, frag_last = 0; frag_x, frag_y = 0.

Configuration
REQ-033 With SAPH_SCAN_WATCHDOG_EN defined: SHALL add output err (1 bit, reset 0); an 8-bit counter runs in PX_WAIT/ROW_WAIT; on reaching 255 cycles without the awaited ready, SHALL pulse err and done for one cycle and go IDLE.
REQ-034 Without SAPH_SCAN_WATCHDOG_EN: no err port, no counter; wait states wait indefinitely.

Verification
REQ-035 Box (2,5)-(3,6), frag_ready=1, ready returned 2 cycles after each count -> fragments (2,5),(3,5),(2,6),(3,6) in order, frag_last only on (3,6), 1 row_latch, 2 px_latch, 2 px_count, 1 row_count pulses, done once.
REQ-036 Box (4,4)-(3,4) -> no frag_valid, done one cycle after start, busy never high.
REQ-037 Box (0,0)-(1,0), frag_ready low 5 cycles at first fragment -> frag_x=0, frag_y=0 stable 6 cycles, no px_count until handshake.
REQ-038 rst asserted in PX_WAIT of a 4x4 box -> next cycle IDLE, all outputs zero, no done; new start scans fully.
REQ-039 Box (65535,0)-(65535,1), cw=16 -> exactly 2 fragments, x stays 65535, terminates.
REQ-040 With SAPH_SCAN_WATCHDOG_EN, px_ready held low after first px_count -> err and done pulse after 255 cycles, busy low afterwards.
